// File: rtl/maf_inv_if.sv
// maf_inv_if: sample-stream bundle for the inverse moving-sum filter.
//   in_valid  - qualifies sum_in (no backpressure)
//   sum_in    - 8-bit moving sum s[k]
//   out_valid - one-cycle pulse, dout holds a recovered sample
//   dout      - 5-bit recovered sample x[k]
//   err       - sticky fault flag
// master drives sums and observes results; slave is the filter side.
interface maf_inv_if;
  logic       in_valid;
  logic [7:0] sum_in;
  logic       out_valid;
  logic [4:0] dout;
  logic       err;

  modport master (output in_valid, output sum_in, input out_valid, input dout, input err);
  modport slave  (input in_valid, input sum_in, output out_valid, output dout, output err);
endinterface

// File: rtl/maf_inv.sv
// maf_inv: reconstructs 5-bit samples from a stream of 6-tap moving sums
// using x[k] = s[k] - s[k-1] + x[k-6].
//   clk   - rising-edge clock
//   reset - asynchronous active-low clear of all state
//   clr   - synchronous restart to PRIME, wins over in_valid
//   bus   - maf_inv_if.slave: in_valid/sum_in in, out_valid/dout/err out
// A sum that would give a sample outside 0..31, or a sum above 6*31, latches
// FAULT; only reset or clr leave it.
module maf_inv (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  maf_inv_if.slave   bus
);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [7:0] SUM_MAX  = 8'd186;
  localparam logic [2:0] CNT_FULL = 3'd6;

  state_t      state_r, state_s;
  logic [7:0]  s_prev_r, s_prev_s;
  logic [4:0]  hist_r [6];
  logic [4:0]  hist_s [6];
  logic [2:0]  cnt_r, cnt_s;
  logic        out_valid_r, out_valid_s;
  logic [4:0]  dout_r, dout_s;
  logic        err_r, err_s;

  logic signed [9:0] d_s;
  logic              legal_s;

  // Candidate sample; widened to 10-bit signed so the range check sees the
  // true value before truncation to 5 bits.
  always_comb begin
    d_s     = $signed({2'b00, bus.sum_in}) - $signed({2'b00, s_prev_r})
            + $signed({5'b00000, hist_r[5]});
    legal_s = (d_s >= 10'sd0) && (d_s <= 10'sd31) && (bus.sum_in <= SUM_MAX);
  end

  // Next-state and output decode; every target holds unless updated below.
  always_comb begin
    state_s     = state_r;
    s_prev_s    = s_prev_r;
    hist_s      = hist_r;
    cnt_s       = cnt_r;
    out_valid_s = 1'b0;
    dout_s      = dout_r;
    err_s       = err_r;
    if (clr) begin
      state_s  = PRIME;
      s_prev_s = 8'd0;
      for (int i = 0; i < 6; i++) hist_s[i] = 5'd0;
      cnt_s    = 3'd0;
      dout_s   = 5'd0;
      err_s    = 1'b0;
    end else begin
      case (state_r)
        PRIME, RUN: begin
          if (bus.in_valid) begin
            if (legal_s) begin
              out_valid_s = 1'b1;
              dout_s      = d_s[4:0];
              s_prev_s    = bus.sum_in;
              for (int i = 5; i > 0; i--) hist_s[i] = hist_r[i-1];
              hist_s[0]   = d_s[4:0];
              if (cnt_r != CNT_FULL) begin
                cnt_s = cnt_r + 3'd1;
              end else begin
                cnt_s = cnt_r;
              end
              // Sixth legal sample fills the history window.
              if ((state_r == PRIME) && (cnt_r == 3'd5)) begin
                state_s = RUN;
              end else begin
                state_s = state_r;
              end
            end else begin
              err_s   = 1'b1;
              state_s = FAULT;
            end
          end else begin
            state_s = state_r;
          end
        end
        FAULT: begin
          err_s = 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into FAULT.
          err_s   = 1'b1;
          state_s = FAULT;
        end
      endcase
    end
  end

  // State and registered outputs, asynchronously cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= PRIME;
      s_prev_r    <= 8'd0;
      for (int i = 0; i < 6; i++) hist_r[i] <= 5'd0;
      cnt_r       <= 3'd0;
      out_valid_r <= 1'b0;
      dout_r      <= 5'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      s_prev_r    <= s_prev_s;
      for (int i = 0; i < 6; i++) hist_r[i] <= hist_s[i];
      cnt_r       <= cnt_s;
      out_valid_r <= out_valid_s;
      dout_r      <= dout_s;
      err_r       <= err_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dout      = dout_r;
  assign bus.err       = err_r;

endmodule
